operand_a_stage: RTL and testbench
==================================

# operand_a_stage

Registered, forwarding-aware operand-A stage for the decode→execute boundary of the core. Chooses operand A (rs1, PC or zero) from lui/jal/jalr/auipc decode flags, resolves rs1 against NUM_FWD in-flight writeback sources, and stalls on load-use hazards. Holds the selected operand and its select code in a one-entry valid/ready pipeline register that feeds the ALU.

## Interface
- XLEN, 32, datapath width.
- NUM_FWD, 3, forwarding sources; index 0 is the youngest (EX) and has the highest priority.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  decode slot valid.
- in_ready_o  out  1  stage accepts this cycle.
- lui_i, jal_i, jalr_i, auipc_i  in  1 each  decode flags.
- rs1_addr_i  in  5  source register index.
- rs1_data_i  in  XLEN  register-file read data.
- pc_i  in  XLEN  instruction PC.
- fwd_valid_i  in  NUM_FWD  source k writes fwd_rd_i[k].
- fwd_pending_i  in  NUM_FWD  source k data not yet available (load in flight).
- fwd_rd_i  in  5*NUM_FWD  destination indices, packed, k at [5k+4:5k].
- fwd_data_i  in  XLEN*NUM_FWD  forwarded data, packed.
- flush_i  in  1  kill the held entry and the current input.
- out_valid_o  out  1  entry held.
- out_ready_i  in  1  execute consumes.
- opa_o  out  XLEN  registered operand A.
- opasel_o  out  2  registered select: 00 rs1, 01 PC, 10 zero.
- stall_o  out  1  combinational hazard stall, this cycle.
- stall_cnt_o  out  STALL_CNT_W  saturating count of stall cycles.

## Operation
- Select priority: lui→10 (opa=0); else jal|jalr|auipc→01 (opa=pc_i); else 00.
- For sel 00: rs1_addr_i==0 → opa=0, no forwarding and no stall. Otherwise take the lowest k with fwd_valid_i[k] and fwd_rd_i[k]==rs1_addr_i.
  - That k pending → hazard.
  - That k not pending → opa=fwd_data_i[k].
  - No match → opa=rs1_data_i.
  - A pending source at a higher index is ignored when a lower-index match exists.
- stall_o = in_valid_i & hazard & !flush_i. Sel 01 and 10 never stall.
- in_ready_o = (!out_valid_o | out_ready_i) & !stall_o & !flush_i.
- Accept = in_valid_i & in_ready_o. On accept, register opa and opasel and set out_valid_o.
- States:
  - EMPTY (out_valid_o=0).
  - FULL (out_valid_o=1).
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with out_ready_i=1, which is back-to-back.
  - FULL→EMPTY on out_ready_i=1 with no accept.
  - FULL holds with opa_o and opasel_o stable while out_ready_i=0.
  - flush_i → EMPTY next cycle from either state. Flush overrides accept and out_ready_i.
- stall_cnt_o increments by 1 each cycle stall_o=1 and saturates at all-ones. It is cleared only by reset.

## Timing
- Reset values: out_valid_o=0, opa_o=0, opasel_o=00, stall_cnt_o=0, state EMPTY. in_ready_o=1 while in reset. Reset asserted mid-transfer drops the held entry immediately.
- Latency: 1 cycle from accept to out_valid_o. Throughput: 1/cycle with out_ready_i held high.
- in_ready_o and stall_o are combinational from inputs and state. Outputs opa_o, opasel_o and out_valid_o are registered only.
- Valid/ready rules:
  - A held entry is never changed or dropped except by flush or reset.
  - An upstream slot stalled by a hazard re-evaluates every cycle. It is accepted in the first cycle the pending bit clears, using the fwd_data_i of that cycle.
- Stall and a full, blocked output together: in_ready_o=0. The counter counts only hazard cycles, not backpressure.

## Test plan
- Reset then lui, pc_i=0x100 → opasel_o=10, opa_o=0, out_valid_o=1 one cycle later. jal with pc_i=0x200 → 01, 0x200. jalr → 01. lui+jal together → 10.
- rs1=5, fwd0 rd=5 data=0xAAAA, fwd2 rd=5 data=0xBBBB, both valid → opa_o=0xAAAA. Drop fwd0 → 0xBBBB. No match, rs1_data_i=0x1234 → 0x1234.
- rs1=0, fwd0 rd=0 pending, rs1_data_i=0xFFFF → no stall, opa_o=0.
- rs1=7, fwd1 rd=7 pending for 3 cycles then data 0x55 → stall_o high 3 cycles, stall_cnt_o=3, accepted on cycle 4, opa_o=0x55.
- Accept, then out_ready_i=0 for 4 cycles while new inputs are offered → opa_o stable, in_ready_o=0. Release → back-to-back transfers at 1/cycle.
- flush_i while FULL with in_valid_i=1 → out_valid_o=0 next cycle, input not captured. Reset asserted mid-stall with stall_cnt_o=0xFFFF (STALL_CNT_W=16) → all outputs at reset values immediately.

Source files
------------

// File: rtl/operand_a_stage.sv
// Operand-A stage at the decode/execute boundary: picks rs1, PC or zero, resolves rs1
// against in-flight writeback sources, stalls on load-use and holds one result for the ALU.
module operand_a_stage #(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    lui_i,
    input  logic                    jal_i,
    input  logic                    jalr_i,
    input  logic                    auipc_i,
    input  logic [4:0]              rs1_addr_i,
    input  logic [XLEN-1:0]         rs1_data_i,
    input  logic [XLEN-1:0]         pc_i,

    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic [NUM_FWD-1:0]      fwd_pending_i,
    input  logic [5*NUM_FWD-1:0]    fwd_rd_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,

    input  logic                    flush_i,

    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         opa_o,
    output logic [1:0]              opasel_o,

    output logic                    stall_o,
    output logic [STALL_CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic [1:0] SEL_RS1  = 2'b00;
    localparam logic [1:0] SEL_PC   = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e                 state_q;
    state_e                 state_d;
    logic                   vld_p0;
    logic [XLEN-1:0]        opa_p0;
    logic [1:0]             opasel_p0;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic [1:0]             sel_c;
    logic [XLEN-1:0]        opa_c;
    logic                   hazard_c;
    logic                   ready_c;
    logic                   accept_c;

    // Walking from the oldest source down to index 0 lets the youngest match overwrite
    // any older one, so a pending older source never masks a ready younger one.
    always_comb begin
        sel_c    = SEL_RS1;
        opa_c    = rs1_data_i;
        hazard_c = 1'b0;
        if (lui_i) begin
            sel_c = SEL_ZERO;
            opa_c = '0;
        end else if (jal_i || jalr_i || auipc_i) begin
            sel_c = SEL_PC;
            opa_c = pc_i;
        end else if (rs1_addr_i == 5'd0) begin
            opa_c = '0;
        end else begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_valid_i[k] && (fwd_rd_i[5*k +: 5] == rs1_addr_i)) begin
                    hazard_c = fwd_pending_i[k];
                    opa_c    = fwd_data_i[XLEN*k +: XLEN];
                end
            end
        end
    end

    assign vld_p0   = (state_q == FULL);
    assign stall_o  = in_valid_i & hazard_c & ~flush_i;
    assign ready_c  = (~vld_p0 | out_ready_i) & ~stall_o & ~flush_i;
    assign accept_c = in_valid_i & ready_c;

    // Reset empties the register, so upstream sees a free slot throughout reset.
    assign in_ready_o = ready_c | rst_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept_c) state_d = FULL;
            FULL:  if (!accept_c && out_ready_i) state_d = EMPTY;
        endcase
        if (flush_i) state_d = EMPTY;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- stage p0: held operand and select ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opa_p0    <= '0;
            opasel_p0 <= SEL_RS1;
        end else if (accept_c) begin
            opa_p0    <= opa_c;
            opasel_p0 <= sel_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign out_valid_o = vld_p0;
    assign opa_o       = opa_p0;
    assign opasel_o    = opasel_p0;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_operand_a_stage.sv
// Directed plus randomized checks of operand_a_stage against a transaction-level model.
module tb_operand_a_stage;

    localparam int XLEN = 32;
    localparam int NF   = 3;
    localparam int CW   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic             lui, jal, jalr, auipc;
    logic [4:0]       rs1_addr;
    logic [XLEN-1:0]  rs1_data, pc;
    logic [NF-1:0]    fwd_valid, fwd_pending;
    logic [5*NF-1:0]  fwd_rd;
    logic [XLEN*NF-1:0] fwd_data;
    logic             flush;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  opa;
    logic [1:0]       opasel;
    logic             stall;
    logic [CW-1:0]    stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model of the stage: one optional held entry plus a stall tally.
    logic             m_valid;
    logic [XLEN-1:0]  m_opa;
    logic [1:0]       m_sel;
    logic [CW-1:0]    m_cnt;

    operand_a_stage #(.XLEN(XLEN), .NUM_FWD(NF), .STALL_CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .lui_i(lui), .jal_i(jal), .jalr_i(jalr), .auipc_i(auipc),
        .rs1_addr_i(rs1_addr), .rs1_data_i(rs1_data), .pc_i(pc),
        .fwd_valid_i(fwd_valid), .fwd_pending_i(fwd_pending),
        .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .opa_o(opa), .opasel_o(opasel),
        .stall_o(stall), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Decode-rule reference: which operand the slot wants and whether it must wait.
    task automatic ref_eval(output logic haz, output logic [1:0] sel, output logic [XLEN-1:0] v);
        int hit;
        haz = 1'b0;
        hit = -1;
        if (lui) begin
            sel = 2'b10; v = 0;
        end else if (jal || jalr || auipc) begin
            sel = 2'b01; v = pc;
        end else begin
            sel = 2'b00;
            v = rs1_data;
            if (rs1_addr == 0) begin
                v = 0;
            end else begin
                for (int k = 0; k < NF; k++)
                    if (hit < 0 && fwd_valid[k] && fwd_rd[5*k +: 5] == rs1_addr) hit = k;
                if (hit >= 0) begin
                    haz = fwd_pending[hit];
                    v = fwd_data[XLEN*hit +: XLEN];
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".opa"}, opa, m_opa);
        check({tag, ".sel"}, 32'(opasel), 32'(m_sel));
        check({tag, ".cnt"}, 32'(stall_cnt), 32'(m_cnt));
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step(input string tag);
        logic haz, e_stall, e_ready;
        logic [1:0] sel;
        logic [XLEN-1:0] v;
        #1;
        ref_eval(haz, sel, v);
        e_stall = in_valid && haz && !flush;
        e_ready = (!m_valid || out_ready) && !e_stall && !flush;
        check({tag, ".stall"}, 32'(stall), 32'(e_stall));
        check({tag, ".ready"}, 32'(in_ready), 32'(e_ready));
        if (flush) m_valid = 1'b0;
        else if (in_valid && e_ready) begin
            m_valid = 1'b1; m_opa = v; m_sel = sel;
        end else if (out_ready) m_valid = 1'b0;
        if (e_stall && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        in_valid = 0; lui = 0; jal = 0; jalr = 0; auipc = 0;
        rs1_addr = 0; rs1_data = 0; pc = 0;
        fwd_valid = 0; fwd_pending = 0; fwd_rd = 0; fwd_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic set_fwd(input int k, input logic v, input logic p,
                           input logic [4:0] rd, input logic [XLEN-1:0] d);
        fwd_valid[k] = v;
        fwd_pending[k] = p;
        fwd_rd[5*k +: 5] = rd;
        fwd_data[XLEN*k +: XLEN] = d;
    endtask

    task automatic model_reset();
        m_valid = 0; m_opa = 0; m_sel = 0; m_cnt = 0;
    endtask

    initial begin
        logic [CW-1:0] cnt0;
        idle();
        model_reset();
        rst = 1;
        #1;
        check_outputs("reset");
        check("reset.ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        // Select priority
        in_valid = 1; lui = 1; pc = 32'h100;
        step("lui");
        check("lui.sel_abs", 32'(opasel), 32'd2);
        lui = 0; jal = 1; pc = 32'h200;
        step("jal");
        check("jal.opa_abs", opa, 32'h200);
        jal = 0; jalr = 1; pc = 32'h300;
        step("jalr");
        jalr = 0; lui = 1; jal = 1;
        step("lui_jal");
        lui = 0; jal = 0; auipc = 1; pc = 32'h444;
        step("auipc");
        auipc = 0;

        // Forwarding priority
        rs1_addr = 5; rs1_data = 32'h1234;
        set_fwd(0, 1, 0, 5, 32'hAAAA);
        set_fwd(2, 1, 0, 5, 32'hBBBB);
        step("fwd0");
        check("fwd0.abs", opa, 32'hAAAA);
        set_fwd(0, 0, 0, 5, 32'hAAAA);
        step("fwd2");
        check("fwd2.abs", opa, 32'hBBBB);
        set_fwd(2, 0, 0, 5, 32'hBBBB);
        step("rf");
        check("rf.abs", opa, 32'h1234);
        set_fwd(0, 1, 0, 5, 32'hC0DE);
        set_fwd(2, 1, 1, 5, 32'hDEAD);
        step("fwd_young_over_pending");

        // x0 never forwards or stalls
        idle(); in_valid = 1;
        rs1_addr = 0; rs1_data = 32'hFFFF;
        set_fwd(0, 1, 1, 0, 32'h9999);
        step("x0");
        check("x0.abs", opa, 32'h0);

        // Load-use stall for three cycles
        idle(); in_valid = 1;
        rs1_addr = 7; rs1_data = 32'h7777;
        set_fwd(1, 1, 1, 7, 32'h0);
        cnt0 = stall_cnt;
        for (int i = 0; i < 3; i++) step("loaduse");
        check("loaduse.cnt3", 32'(stall_cnt - cnt0), 32'd3);
        set_fwd(1, 1, 0, 7, 32'h55);
        step("loaduse_go");
        check("loaduse.abs", opa, 32'h55);

        // Backpressure then back-to-back
        idle(); in_valid = 1; jal = 1; pc = 32'hA0;
        step("bp_fill");
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            pc = 32'hB0 + 32'(i);
            step("bp_hold");
        end
        check("bp.opa_stable", opa, 32'hA0);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'hC0 + 32'(i);
            step("b2b");
        end
        check("b2b.last", opa, 32'hC3);
        in_valid = 0;
        step("drain");

        // Flush while full with a live input
        in_valid = 1; jal = 1; pc = 32'hD0;
        step("fl_fill");
        out_ready = 0; pc = 32'hE0; flush = 1;
        step("flush");
        check("flush.opa_kept", opa, 32'hD0);
        flush = 0; out_ready = 1;
        step("post_flush");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            lui = 1'($urandom_range(0, 7) == 0);
            jal = 1'($urandom_range(0, 7) == 0);
            jalr = 1'($urandom_range(0, 9) == 0);
            auipc = 1'($urandom_range(0, 9) == 0);
            rs1_addr = 5'($urandom_range(0, 3));
            rs1_data = $urandom;
            pc = $urandom;
            for (int k = 0; k < NF; k++)
                set_fwd(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                        5'($urandom_range(0, 3)), $urandom);
            flush = 1'($urandom_range(0, 15) == 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            step("rand");
        end

        // Counter saturation, then reset in the middle of a stall
        idle(); in_valid = 1; out_ready = 0;
        rs1_addr = 9;
        set_fwd(0, 1, 1, 9, 32'h0);
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        check("sat.cnt", 32'(stall_cnt), 32'h0000FFFF);
        check("sat.stall", 32'(stall), 32'd1);
        #2;
        rst = 1;
        #1;
        model_reset();
        check_outputs("midreset");
        check("midreset.ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 0;
        idle();
        step("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
